// File: rtl/dac_ctrl_pkg.sv
// Shared DAC_Controller definitions: the arbiter state type and the RTO_Core
// command word width.
// Ports: none (package).
package dac_ctrl_pkg;

  localparam int RTO_CMD_WIDTH = 128;

  typedef enum logic {
    ARB_IDLE,
    ARB_GRANT
  } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: returns the first set bit of valid_i
// scanning upward from last_i+1, wrapping modulo NUM_REQ.
// Ports: valid_i (request vector), last_i (previous winner) -> idx_o, found_o.
module rr_picker #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         valid_i,
  input  logic [$clog2(NUM_REQ)-1:0] last_i,
  output logic [$clog2(NUM_REQ)-1:0] idx_o,
  output logic                       found_o
);

  localparam int IW = $clog2(NUM_REQ);

  logic [IW-1:0] cand;

  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    cand    = '0;
    // k runs 1..NUM_REQ so the previous winner is examined last.
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IW'((int'(last_i) + k) % NUM_REQ);
      if (!found_o && valid_i[cand]) begin
        idx_o   = cand;
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dds_cmd_arbiter.sv
// Burst-granular round-robin arbiter sharing the RTO_Core command-write port
// between NUM_REQ timed-command sources; stalls on full, aborts on flush.
// Ports: s_axi_aclk/s_axi_aresetn, req_valid/req_data/req_last/req_ready,
//        rto_core_full/flush in, rto_core_write/fifo_din out,
//        grant_valid/grant_id/burst_error status.
module dds_cmd_arbiter
  import dac_ctrl_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = RTO_CMD_WIDTH,
  parameter int MAX_BURST  = 16
) (
  input  logic                          s_axi_aclk,
  input  logic                          s_axi_aresetn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          rto_core_full,
  input  logic                          rto_core_flush,
  output logic                          rto_core_write,
  output logic [DATA_WIDTH-1:0]         rto_core_fifo_din,
  output logic                          grant_valid,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          burst_error
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  arb_state_t    state_q, state_d;
  logic [IW-1:0] grant_id_q, grant_id_d;
  logic [IW-1:0] last_grant_q, last_grant_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;
  logic          burst_err_q, burst_err_d;

  logic [IW-1:0] pick_idx;
  logic          pick_found;
  logic [CW-1:0] beat_next;
  logic          port_ok;
  logic [DATA_WIDTH-1:0] req_words [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign req_words[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .valid_i (req_valid),
    .last_i  (last_grant_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  assign beat_next = beat_cnt_q + CW'(1);
  // Reset is folded in so a burst dropped by reset cannot emit one last write
  // in the reset cycle itself.
  assign port_ok   = s_axi_aresetn & ~rto_core_full & ~rto_core_flush;

  always_comb begin
    state_d           = state_q;
    grant_id_d        = grant_id_q;
    last_grant_d      = last_grant_q;
    beat_cnt_d        = beat_cnt_q;
    burst_err_d       = 1'b0;
    req_ready         = '0;
    rto_core_write    = 1'b0;
    rto_core_fifo_din = '0;
    case (state_q)
      ARB_IDLE: begin
        if (!rto_core_flush && pick_found) begin
          grant_id_d   = pick_idx;
          last_grant_d = pick_idx;
          beat_cnt_d   = '0;
          state_d      = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        req_ready[grant_id_q] = port_ok;
        if (rto_core_flush) begin
          // last_grant_q is left alone so the aborted source gets no priority.
          state_d = ARB_IDLE;
        end else if (port_ok && req_valid[grant_id_q]) begin
          rto_core_write    = 1'b1;
          rto_core_fifo_din = req_words[grant_id_q];
          beat_cnt_d        = beat_next;
          if (req_last[grant_id_q]) begin
            state_d = ARB_IDLE;
          end else if (beat_next == CW'(MAX_BURST)) begin
            state_d     = ARB_IDLE;
            burst_err_d = 1'b1;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      state_q      <= ARB_IDLE;
      grant_id_q   <= '0;
      last_grant_q <= IW'(NUM_REQ - 1);
      beat_cnt_q   <= '0;
      burst_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      burst_err_q  <= burst_err_d;
    end
  end

  assign grant_valid = (state_q == ARB_GRANT);
  assign grant_id    = grant_id_q;
  assign burst_error = burst_err_q;

endmodule

// File: tb/tb_dds_cmd_arbiter.sv
module tb_dds_cmd_arbiter;
  localparam int N  = 2;
  localparam int DW = 128;
  localparam int MB = 16;
  localparam int HN = 8192;

  logic            clk = 1'b0;
  logic            rstn;
  logic [N-1:0]    req_valid, req_last, req_ready;
  logic [N*DW-1:0] req_data;
  logic            full, flush;
  logic            wr;
  logic [DW-1:0]   din;
  logic            gv;
  logic [0:0]      gid;
  logic            err;

  always #5 clk = ~clk;

  dds_cmd_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .s_axi_aclk        (clk),
    .s_axi_aresetn     (rstn),
    .req_valid         (req_valid),
    .req_data          (req_data),
    .req_last          (req_last),
    .req_ready         (req_ready),
    .rto_core_full     (full),
    .rto_core_flush    (flush),
    .rto_core_write    (wr),
    .rto_core_fifo_din (din),
    .grant_valid       (gv),
    .grant_id          (gid),
    .burst_error       (err)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Source-side word queues: {last, data}
  logic [128:0] q0[$];
  logic [128:0] q1[$];
  bit [1:0] en_v = 2'b11;
  bit full_v = 0, flush_v = 0, rst_v = 1;
  logic [1:0] hs;

  function automatic logic [127:0] mkw(input int src, input int n);
    return {8'(160 + src), 88'h0, 32'(n)};
  endfunction

  task automatic push(input int src, input int n, input bit last);
    if (src == 0) q0.push_back({last, mkw(src, n)});
    else          q1.push_back({last, mkw(src, n)});
  endtask

  task automatic drive();
    rstn  = ~rst_v;
    full  = full_v;
    flush = flush_v;
    req_valid[0]     = en_v[0] && (q0.size() > 0);
    req_last[0]      = (q0.size() > 0) ? q0[0][128] : 1'b0;
    req_data[127:0]  = (q0.size() > 0) ? q0[0][127:0] : '0;
    req_valid[1]     = en_v[1] && (q1.size() > 0);
    req_last[1]      = (q1.size() > 0) ? q1[0][128] : 1'b0;
    req_data[255:128]= (q1.size() > 0) ? q1[0][127:0] : '0;
  endtask

  task automatic step();
    @(negedge clk);
    hs = req_valid & req_ready;
    @(posedge clk);
    #1;
    if (hs[0]) void'(q0.pop_front());
    if (hs[1]) void'(q1.pop_front());
    drive();
  endtask

  task automatic do_reset();
    rst_v = 1;
    repeat (2) step();
    rst_v = 0;
    step();
  endtask

  // Per-cycle history of DUT outputs for the directed literal checks
  bit            wr_h  [HN];
  bit            gv_h  [HN];
  bit            err_h [HN];
  bit            gid_h [HN];
  logic [1:0]    rdy_h [HN];
  logic [127:0]  din_h [HN];

  // Behavioural reference: whole-burst ownership, round-robin from the last
  // owner, at most MB beats per ownership.
  initial begin
    bit busy, errm, init, beat, fnd;
    int gidm, lastg, beats, c;
    logic [1:0] exp_ready;
    init = 0; busy = 0; errm = 0; gidm = 0; lastg = N - 1; beats = 0;
    forever begin
      @(negedge clk);
      if (cyc < HN) begin
        wr_h[cyc] = wr; gv_h[cyc] = gv; err_h[cyc] = err; gid_h[cyc] = gid[0];
        rdy_h[cyc] = req_ready; din_h[cyc] = din;
      end
      if (rstn !== 1'b1) begin
        chk("rst_cycle_write", wr, 0);
        chk("rst_cycle_ready", req_ready, 0);
        chk("rst_cycle_din", din, 0);
        busy = 0; errm = 0; gidm = 0; lastg = N - 1; beats = 0; init = 1;
      end else if (init) begin
        exp_ready = 2'b00;
        beat = 0;
        if (busy) begin
          if (!full && !flush) exp_ready[gidm] = 1'b1;
          beat = req_valid[gidm] && exp_ready[gidm];
        end
        chk("grant_valid", gv, busy);
        chk("grant_id", gid, gidm);
        chk("burst_error", err, errm);
        chk("req_ready", req_ready, exp_ready);
        chk("write", wr, beat);
        chk("din", din, beat ? req_data[gidm*DW +: DW] : 128'h0);
        errm = 0;
        if (busy) begin
          if (flush) busy = 0;
          else if (beat) begin
            beats++;
            if (req_last[gidm]) busy = 0;
            else if (beats == MB) begin busy = 0; errm = 1; end
          end
        end else if (!flush && req_valid != 0) begin
          fnd = 0;
          for (int k = 1; k <= N; k++) begin
            c = (lastg + k) % N;
            if (!fnd && req_valid[c]) begin fnd = 1; gidm = c; end
          end
          lastg = gidm; beats = 0; busy = 1;
        end
      end
    end
  end

  initial begin
    int t, ecnt;
    drive();
    repeat (3) step();
    rst_v = 0;
    step();
    t = cyc;
    step();
    // Reset state
    chk("reset_write", wr_h[t], 0);
    chk("reset_gv", gv_h[t], 0);
    chk("reset_gid", gid_h[t], 0);
    chk("reset_err", err_h[t], 0);
    chk("reset_ready", rdy_h[t], 0);

    // Single 3-beat burst from requester 0
    push(0, 0, 0); push(0, 1, 0); push(0, 2, 1);
    step(); t = cyc;
    repeat (6) step();
    chk("t1_idle_wr", wr_h[t], 0);
    for (int i = 0; i < 3; i++) begin
      chk("t1_wr", wr_h[t+1+i], 1);
      chk("t1_din", din_h[t+1+i], mkw(0, i));
    end
    chk("t1_gv_drop", gv_h[t+4], 0);
    chk("t1_wr_after", wr_h[t+4], 0);

    // Two requesters, 2-beat bursts, twice each
    do_reset();
    push(0, 10, 0); push(0, 11, 1); push(0, 12, 0); push(0, 13, 1);
    push(1, 10, 0); push(1, 11, 1); push(1, 12, 0); push(1, 13, 1);
    step(); t = cyc;
    repeat (14) step();
    for (int b = 0; b < 4; b++) begin
      int base, s, n;
      base = t + 1 + 3 * b; s = b % 2; n = 10 + 2 * (b / 2);
      chk("t2_wr0", wr_h[base], 1);
      chk("t2_din0", din_h[base], mkw(s, n));
      chk("t2_gid", gid_h[base], s);
      chk("t2_wr1", wr_h[base+1], 1);
      chk("t2_din1", din_h[base+1], mkw(s, n + 1));
      chk("t2_bubble", wr_h[base+2], 0);
    end

    // Full stall on beat 2
    push(0, 30, 0); push(0, 31, 0); push(0, 32, 1);
    step(); t = cyc;
    step();
    full_v = 1; repeat (4) step();
    full_v = 0; repeat (4) step();
    chk("t3_b1", din_h[t+1], mkw(0, 30));
    for (int k = 2; k <= 5; k++) begin
      chk("t3_stall_wr", wr_h[t+k], 0);
      chk("t3_stall_gv", gv_h[t+k], 1);
      chk("t3_stall_gid", gid_h[t+k], 0);
    end
    chk("t3_b2", din_h[t+6], mkw(0, 31));
    chk("t3_b3", din_h[t+7], mkw(0, 32));
    chk("t3_done", gv_h[t+8], 0);

    // MAX_BURST forced exit
    for (int i = 0; i < 20; i++) push(1, 40 + i, i == 19);
    push(0, 70, 1);
    step(); t = cyc;
    repeat (26) step();
    for (int i = 0; i < 16; i++) chk("t4_r1", din_h[t+1+i], mkw(1, 40 + i));
    chk("t4_err", err_h[t+17], 1);
    chk("t4_gap_wr", wr_h[t+17], 0);
    ecnt = 0;
    for (int k = 0; k <= 26; k++) ecnt += int'(err_h[t+k]);
    chk("t4_err_once", ecnt, 1);
    chk("t4_r0", din_h[t+18], mkw(0, 70));
    chk("t4_r0_gid", gid_h[t+18], 0);
    for (int i = 0; i < 4; i++) chk("t4_rest", din_h[t+20+i], mkw(1, 56 + i));
    chk("t4_done", gv_h[t+24], 0);

    // Flush on beat 2
    for (int i = 0; i < 4; i++) push(0, 80 + i, i == 3);
    push(1, 90, 1);
    step(); t = cyc;
    step();
    flush_v = 1; step();
    flush_v = 0; repeat (8) step();
    chk("t5_b1", din_h[t+1], mkw(0, 80));
    chk("t5_flush_wr", wr_h[t+2], 0);
    chk("t5_idle", gv_h[t+3], 0);
    chk("t5_next", din_h[t+4], mkw(1, 90));
    chk("t5_next_gid", gid_h[t+4], 1);
    for (int i = 0; i < 3; i++) chk("t5_rest", din_h[t+6+i], mkw(0, 81 + i));

    // Reset mid-burst
    for (int i = 0; i < 5; i++) push(0, 100 + i, i == 4);
    step(); t = cyc;
    step(); step();
    rst_v = 1; step();
    rst_v = 0; step();
    repeat (8) step();
    chk("t6_b2", din_h[t+2], mkw(0, 101));
    chk("t6_rst_wr", wr_h[t+3], 0);
    chk("t6_post_wr", wr_h[t+4], 0);
    chk("t6_post_gv", gv_h[t+4], 0);
    chk("t6_post_err", err_h[t+4], 0);
    chk("t6_post_gid", gid_h[t+4], 0);
    chk("t6_post_din", din_h[t+4], 0);
    chk("t6_post_rdy", rdy_h[t+4], 0);

    // Randomised traffic against the model
    do_reset();
    begin
      int nseq;
      nseq = 1000;
      for (int r = 0; r < 1500; r++) begin
        if ($urandom_range(3) == 0) begin
          int s, len;
          s = int'($urandom_range(1));
          len = int'($urandom_range(22, 1));
          if ((s == 0 ? q0.size() : q1.size()) < 8)
            for (int i = 0; i < len; i++) begin push(s, nseq, i == len - 1); nseq++; end
        end
        en_v    = 2'($urandom_range(3));
        full_v  = ($urandom_range(4) == 0);
        flush_v = ($urandom_range(29) == 0);
        step();
      end
    end
    full_v = 0; flush_v = 0;
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
